// File: rtl/qsys_system_nios2_oci_pkg.sv
// Shared constants for the Nios II OCI trace blocks: DCT frame geometry and
// drain-sequencer state encodings.
package qsys_system_nios2_oci_pkg;

    localparam int unsigned DCT_ENTRY_W = 2;
    localparam int unsigned DCT_DEPTH   = 15;
    localparam int unsigned DCT_BUF_W   = DCT_ENTRY_W * DCT_DEPTH;
    localparam int unsigned DCT_CNT_W   = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ENDED = 2'd2;

endpackage

// File: rtl/qsys_system_nios2_oci_dct_accum.sv
// DCT shift accumulator: newest code enters at the LSBs; exposes both the
// registered contents and the next-state values used for zero-latency launch.
module qsys_system_nios2_oci_dct_accum
    import qsys_system_nios2_oci_pkg::*;
#(
    parameter int unsigned ENTRY_W = DCT_ENTRY_W,
    parameter int unsigned DEPTH   = DCT_DEPTH,
    parameter int unsigned BUF_W   = DCT_BUF_W,
    parameter int unsigned CNT_W   = DCT_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] in_code,
    output logic [BUF_W-1:0]   acc_buf,
    output logic [CNT_W-1:0]   acc_cnt,
    output logic [BUF_W-1:0]   next_buf,
    output logic [CNT_W-1:0]   next_cnt
);

    logic [BUF_W-1:0] acc_buf_q, acc_buf_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        next_buf = acc_buf_q;
        next_cnt = acc_cnt_q;
        if (accept) begin
            next_buf = {acc_buf_q[BUF_W-ENTRY_W-1:0], in_code};
            next_cnt = acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        // A launched frame leaves the accumulator empty so partial frames carry zero upper entries.
        acc_buf_d = clear ? '0 : next_buf;
        acc_cnt_d = clear ? '0 : next_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            acc_buf_q <= acc_buf_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign acc_buf = acc_buf_q;
    assign acc_cnt = acc_cnt_q;

endmodule

// File: rtl/qsys_system_nios2_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into {count, payload} frames with a one-deep
// valid/ready output slot and an end-of-test drain sequencer.
module qsys_system_nios2_oci_dct_packer
    import qsys_system_nios2_oci_pkg::*;
#(
    parameter int unsigned ENTRY_W = DCT_ENTRY_W,
    parameter int unsigned DEPTH   = DCT_DEPTH,
    parameter int unsigned BUF_W   = DCT_BUF_W,
    parameter int unsigned CNT_W   = DCT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [ENTRY_W-1:0]     in_code,
    output logic                   in_ready,
    input  logic                   flush_req,
    input  logic                   test_ending,
    output logic                   out_valid,
    output logic [CNT_W+BUF_W-1:0] out_data,
    input  logic                   out_ready,
    output logic [BUF_W-1:0]       dct_buffer,
    output logic [CNT_W-1:0]       dct_count,
    output logic                   test_has_ended
);

    logic [1:0]             state_q, state_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   out_valid_q, out_valid_d;
    logic [CNT_W+BUF_W-1:0] out_data_q, out_data_d;

    logic             accept, slot_free, want, launch;
    logic [BUF_W-1:0] acc_buf, next_buf;
    logic [CNT_W-1:0] acc_cnt, next_cnt;

    qsys_system_nios2_oci_dct_accum #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .BUF_W   (BUF_W),
        .CNT_W   (CNT_W)
    ) u_accum (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .clear    (launch),
        .in_code  (in_code),
        .acc_buf  (acc_buf),
        .acc_cnt  (acc_cnt),
        .next_buf (next_buf),
        .next_cnt (next_cnt)
    );

    always_comb begin
        in_ready  = (state_q == ST_RUN) && (acc_cnt != CNT_W'(DEPTH));
        accept    = in_valid & in_ready;
        slot_free = ~out_valid_q | out_ready;
        want      = (next_cnt == CNT_W'(DEPTH))
                  | ((flush_pend_q | flush_req) & (next_cnt != '0));
        launch    = want & slot_free;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        flush_pend_d = 1'b0;
        state_d      = state_q;

        if (launch) begin
            out_valid_d = 1'b1;
            out_data_d  = {next_cnt, next_buf};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A pending flush survives only while its frame is blocked; an empty flush simply clears.
        if (want && !slot_free)
            flush_pend_d = flush_pend_q | flush_req;

        case (state_q)
            ST_RUN: begin
                if (test_ending) begin
                    state_d      = ST_DRAIN;
                    flush_pend_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if ((acc_cnt == '0) && !out_valid_q && !flush_pend_q)
                    state_d = ST_ENDED;
            end
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign dct_buffer     = acc_buf;
    assign dct_count      = acc_cnt;
    assign test_has_ended = (state_q == ST_ENDED);

endmodule

// File: tb/tb_qsys_system_nios2_oci_dct_packer.sv
// Directed self-checking bench for the DCT packer: full/partial frames,
// backpressure, flush corner cases, end-of-test drain and mid-frame reset.
module tb_qsys_system_nios2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_code;
    logic        in_ready;
    logic        flush_req;
    logic        test_ending;
    logic        out_valid;
    logic [33:0] out_data;
    logic        out_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    qsys_system_nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_code        (in_code),
        .in_ready       (in_ready),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_code = 2'b00; flush_req = 1'b0;
        test_ending = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 34'd0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
        n_total++; if (dct_count !== 4'd0) $display("FAIL reset_dct_count got %0d exp 0", dct_count); else n_pass++;
        n_total++; if (dct_buffer !== 30'd0) $display("FAIL reset_dct_buffer got %h exp 0", dct_buffer); else n_pass++;
        n_total++; if (test_has_ended !== 1'b0) $display("FAIL reset_ended got %b exp 0", test_has_ended); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_full_frame();
        logic [29:0] exp;
        logic [1:0]  c;
        exp = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            c = 2'((i + 1) % 4);
            exp = {exp[27:0], c};
            in_valid = 1'b1; in_code = c;
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL full_in_ready[%0d] got %b exp 1", i, in_ready); else n_pass++;
            cyc();
        end
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL full_out_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== {4'd15, exp}) $display("FAIL full_out_data got %h exp %h", out_data, {4'd15, exp}); else n_pass++;
        n_total++; if (out_data[1:0] !== 2'b11) $display("FAIL full_last_code got %b exp 11", out_data[1:0]); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL full_in_ready_after got %b exp 1", in_ready); else n_pass++;
        n_total++; if (dct_count !== 4'd0) $display("FAIL full_dct_count got %0d exp 0", dct_count); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL full_drained got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_code = 2'b11;
            cyc();
        end
        in_valid = 1'b0;
        n_total++; if (dct_count !== 4'd3) $display("FAIL flush_pre_count got %0d exp 3", dct_count); else n_pass++;
        n_total++; if (dct_buffer !== 30'h3F) $display("FAIL flush_pre_buffer got %h exp 3f", dct_buffer); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_pre_valid got %b exp 0", out_valid); else n_pass++;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL flush_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== {4'd3, 24'd0, 6'b111111}) $display("FAIL flush_data got %h exp %h", out_data, {4'd3, 24'd0, 6'b111111}); else n_pass++;
        n_total++; if (dct_count !== 4'd0) $display("FAIL flush_count got %0d exp 0", dct_count); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_drained got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [29:0] f1, f2;
        logic [1:0]  c;
        f1 = '0; f2 = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            c = (k < 15) ? 2'(k % 4) : 2'(3 - (k % 4));
            if (k < 15) f1 = {f1[27:0], c}; else f2 = {f2[27:0], c};
            in_valid = 1'b1; in_code = c;
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready[%0d] got %b exp 1", k, in_ready); else n_pass++;
            cyc();
        end
        in_valid = 1'b0;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", in_ready); else n_pass++;
        n_total++; if (dct_count !== 4'd15) $display("FAIL bp_count got %0d exp 15", dct_count); else n_pass++;
        n_total++; if (dct_buffer !== f2) $display("FAIL bp_buffer got %h exp %h", dct_buffer, f2); else n_pass++;
        cyc(); cyc();
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== {4'd15, f1}) $display("FAIL bp_hold_data got %h exp %h", out_data, {4'd15, f1}); else n_pass++;
        out_ready = 1'b1;
        cyc();
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== {4'd15, f2}) $display("FAIL bp_second_data got %h exp %h", out_data, {4'd15, f2}); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", in_ready); else n_pass++;
        n_total++; if (dct_count !== 4'd0) $display("FAIL bp_count_after got %0d exp 0", dct_count); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush_edges();
        logic [29:0] exp;
        exp = '0;
        out_ready = 1'b1;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL empty_flush_valid got %b exp 0", out_valid); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL empty_flush_later got %b exp 0", out_valid); else n_pass++;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_code = 2'b10;
            exp = {exp[27:0], 2'b10};
            cyc();
        end
        in_code = 2'b01; flush_req = 1'b1;
        exp = {exp[27:0], 2'b01};
        cyc();
        in_valid = 1'b0; flush_req = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL flush15_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== {4'd15, exp}) $display("FAIL flush15_data got %h exp %h", out_data, {4'd15, exp}); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush15_single got %b exp 0", out_valid); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush15_no_extra got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_drain();
        logic [9:0] p;
        p = 10'b11_10_01_00_11;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code = (i == 0) ? 2'b11 : (i == 1) ? 2'b10 : (i == 2) ? 2'b01 : (i == 3) ? 2'b00 : 2'b11;
            cyc();
        end
        in_valid = 1'b0;
        test_ending = 1'b1;
        cyc();
        test_ending = 1'b0;
        n_total++; if (in_ready !== 1'b0) $display("FAIL drain_in_ready got %b exp 0", in_ready); else n_pass++;
        cyc();
        n_total++; if (out_valid !== 1'b1) $display("FAIL drain_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_data !== {4'd5, 20'd0, p}) $display("FAIL drain_data got %h exp %h", out_data, {4'd5, 20'd0, p}); else n_pass++;
        cyc();
        n_total++; if (test_has_ended !== 1'b0) $display("FAIL drain_not_ended got %b exp 0", test_has_ended); else n_pass++;
        n_total++; if (out_data !== {4'd5, 20'd0, p}) $display("FAIL drain_hold got %h exp %h", out_data, {4'd5, 20'd0, p}); else n_pass++;
        out_ready = 1'b1;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_accepted got %b exp 0", out_valid); else n_pass++;
        n_total++; if (test_has_ended !== 1'b0) $display("FAIL drain_ended_early got %b exp 0", test_has_ended); else n_pass++;
        cyc();
        n_total++; if (test_has_ended !== 1'b1) $display("FAIL drain_ended got %b exp 1", test_has_ended); else n_pass++;
        test_ending = 1'b1;
        cyc(); cyc();
        test_ending = 1'b0;
        n_total++; if (test_has_ended !== 1'b1) $display("FAIL drain_sticky got %b exp 1", test_has_ended); else n_pass++;
        in_valid = 1'b1; in_code = 2'b01;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL ended_in_ready got %b exp 0", in_ready); else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_total++; if (test_has_ended !== 1'b0) $display("FAIL rst_clears_ended got %b exp 0", test_has_ended); else n_pass++;
        out_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            in_valid = 1'b1; in_code = 2'(i % 4);
            cyc();
        end
        in_valid = 1'b0;
        n_total++; if (dct_count !== 4'd7) $display("FAIL mid_pre_count got %0d exp 7", dct_count); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", out_valid); else n_pass++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (dct_count !== 4'd0) $display("FAIL mid_count got %0d exp 0", dct_count); else n_pass++;
        n_total++; if (dct_buffer !== 30'd0) $display("FAIL mid_buffer got %h exp 0", dct_buffer); else n_pass++;
        n_total++; if (test_has_ended !== 1'b0) $display("FAIL mid_ended got %b exp 0", test_has_ended); else n_pass++;
        out_ready = 1'b1;
        cyc();
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_no_frame got %b exp 0", out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_back_to_back();
        test_flush_edges();
        test_drain();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
